// File: rtl/bp_pkg.sv
// Shared types for the branch target predictor: counter encodings, per-entry
// control state and the predict-taken threshold.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_cnt_e;

    // Width-independent part of an entry; tag and target are kept in
    // separately sized arrays because their widths follow module parameters.
    typedef struct packed {
        logic    valid;
        logic    is_jump;
        bp_cnt_e cnt;
    } bp_entry_t;

    localparam bp_cnt_e PRED_TAKEN_MIN = WT;

endpackage

// File: rtl/bp_counter2.sv
// 2-bit hysteresis counter next-state function.
// Latency: combinational. Backpressure: none.
// Not-taken drops a weak or strongly-not-taken state straight to SNT.
module bp_counter2
    import bp_pkg::*;
(
    input  bp_cnt_e cnt,
    input  logic    taken,
    output bp_cnt_e cnt_next
);

    always_comb begin
        cnt_next = cnt;
        case (cnt)
            SNT:     cnt_next = taken ? WNT : SNT;
            WNT:     cnt_next = taken ? ST  : SNT;
            WT:      cnt_next = taken ? ST  : SNT;
            ST:      cnt_next = taken ? ST  : WT;
            default: cnt_next = SNT;
        endcase
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped, fully tagged BTB with per-entry 2-bit counters and bulk flush.
// Latency: lookup combinational (0 cycles); update visible the cycle after its edge.
// Backpressure: none, one update per cycle. Optional BP_STATS_EN adds saturating stat counters.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int          WORD       = 16,
    parameter int          INDEX_BITS = 3,
    parameter logic [1:0]  CNT_INIT   = 2'd3
) (
    input  logic            Clk,
    input  logic            Reset_N,
    input  logic            lookup_en,
    input  logic [WORD-1:0] lookup_pc,
    output logic [WORD-1:0] pred_pc,
    output logic            pred_taken,
    output logic            pred_hit,
    input  logic            update_valid,
    input  logic [WORD-1:0] update_pc,
    input  logic [WORD-1:0] update_target,
    input  logic            update_is_jump,
    input  logic            update_taken,
    input  logic            update_mispredict,
    input  logic            flush
`ifdef BP_STATS_EN
    ,
    output logic [15:0]     stat_lookups,
    output logic [15:0]     stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = WORD - INDEX_BITS;

    bp_entry_t              ctrl_q [ENTRIES];
    logic [TAG_W-1:0]       tag_q  [ENTRIES];
    logic [WORD-1:0]        tgt_q  [ENTRIES];

    logic [INDEX_BITS-1:0]  lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    bp_entry_t              lk_ctrl;

    logic [INDEX_BITS-1:0]  up_idx;
    logic [TAG_W-1:0]       up_tag;
    bp_entry_t              up_ctrl;
    logic                   up_hit;
    bp_cnt_e                up_cnt_next;
    bp_cnt_e                alloc_cnt;

    assign lk_idx  = lookup_pc[INDEX_BITS-1:0];
    assign lk_tag  = lookup_pc[WORD-1:INDEX_BITS];
    assign lk_ctrl = ctrl_q[lk_idx];

    // No bypass: a same-index update this cycle is not visible here.
    assign pred_hit   = lk_ctrl.valid && (tag_q[lk_idx] == lk_tag);
    assign pred_taken = pred_hit && (lk_ctrl.is_jump || (lk_ctrl.cnt >= PRED_TAKEN_MIN));
    assign pred_pc    = pred_taken ? tgt_q[lk_idx] : lookup_pc + WORD'(1);

    assign up_idx    = update_pc[INDEX_BITS-1:0];
    assign up_tag    = update_pc[WORD-1:INDEX_BITS];
    assign up_ctrl   = ctrl_q[up_idx];
    assign up_hit    = up_ctrl.valid && (tag_q[up_idx] == up_tag);
    assign alloc_cnt = (update_is_jump || update_taken) ? bp_cnt_e'(CNT_INIT) : SNT;

    bp_counter2 u_cnt (
        .cnt      (up_ctrl.cnt),
        .taken    (update_taken),
        .cnt_next (up_cnt_next)
    );

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctrl_q[i] <= '{valid: 1'b0, is_jump: 1'b0, cnt: bp_cnt_e'(CNT_INIT)};
                tag_q[i]  <= '0;
                tgt_q[i]  <= '0;
            end
        end else if (flush) begin
            // Flush takes priority and drops any concurrent update.
            for (int i = 0; i < ENTRIES; i++) begin
                ctrl_q[i].valid <= 1'b0;
            end
        end else if (update_valid) begin
            ctrl_q[up_idx].is_jump <= update_is_jump;
            if (up_hit) begin
                if (update_is_jump) begin
                    tgt_q[up_idx] <= update_target;
                end else begin
                    ctrl_q[up_idx].cnt <= up_cnt_next;
                    if (update_taken) begin
                        tgt_q[up_idx] <= update_target;
                    end
                end
            end else begin
                ctrl_q[up_idx].valid <= 1'b1;
                ctrl_q[up_idx].cnt   <= alloc_cnt;
                tag_q[up_idx]        <= up_tag;
                tgt_q[up_idx]        <= update_target;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_en && (stat_lookups != 16'hFFFF)) begin
                stat_lookups <= stat_lookups + 16'd1;
            end
            if (update_valid && update_mispredict && !flush && (stat_mispredicts != 16'hFFFF)) begin
                stat_mispredicts <= stat_mispredicts + 16'd1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = lookup_en ^ update_mispredict;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor; stat checks run only when BP_STATS_EN is defined.
module tb_branch_target_predictor;

    logic        Clk;
    logic        Reset_N;
    logic        lookup_en;
    logic [15:0] lookup_pc;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic        update_valid;
    logic [15:0] update_pc;
    logic [15:0] update_target;
    logic        update_is_jump;
    logic        update_taken;
    logic        update_mispredict;
    logic        flush;
`ifdef BP_STATS_EN
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_target_predictor #(
        .WORD       (16),
        .INDEX_BITS (3),
        .CNT_INIT   (2'd3)
    ) dut (
        .Clk               (Clk),
        .Reset_N           (Reset_N),
        .lookup_en         (lookup_en),
        .lookup_pc         (lookup_pc),
        .pred_pc           (pred_pc),
        .pred_taken        (pred_taken),
        .pred_hit          (pred_hit),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_target     (update_target),
        .update_is_jump    (update_is_jump),
        .update_taken      (update_taken),
        .update_mispredict (update_mispredict),
        .flush             (flush)
`ifdef BP_STATS_EN
        ,
        .stat_lookups      (stat_lookups),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One update across one edge; inputs return to idle afterwards.
    task automatic do_update(input logic [15:0] pc, input logic [15:0] tgt,
                             input logic jmp, input logic tkn);
        update_pc      = pc;
        update_target  = tgt;
        update_is_jump = jmp;
        update_taken   = tkn;
        update_valid   = 1'b1;
        tick();
        update_valid   = 1'b0;
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        lookup_pc = 16'h0010;
        #1;
        checks++; if (pred_pc !== 16'h0011) begin errors++; $display("FAIL reset_pred_pc: got %h want %h", pred_pc, 16'h0011); end
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        tick();
        tick();
        Reset_N = 1'b1;
        tick();
        #1;
        checks++; if (pred_pc !== 16'h0011) begin errors++; $display("FAIL post_reset_pred_pc: got %h want %h", pred_pc, 16'h0011); end
    endtask

    task automatic test_branch_basic();
        do_update(16'h0012, 16'h0040, 1'b0, 1'b1);
        lookup_pc = 16'h0012;
        #1;
        checks++; if (pred_pc !== 16'h0040) begin errors++; $display("FAIL alloc_taken_pc: got %h want %h", pred_pc, 16'h0040); end
        checks++; if (pred_taken !== 1'b1 || pred_hit !== 1'b1) begin errors++; $display("FAIL alloc_taken_flags: got taken=%b hit=%b want 1 1", pred_taken, pred_hit); end
        do_update(16'h0012, 16'h0040, 1'b0, 1'b0);
        #1;
        checks++; if (pred_pc !== 16'h0040) begin errors++; $display("FAIL cnt3_n_pc: got %h want %h", pred_pc, 16'h0040); end
        do_update(16'h0012, 16'h0040, 1'b0, 1'b0);
        #1;
        checks++; if (pred_pc !== 16'h0013) begin errors++; $display("FAIL cnt2_n_pc: got %h want %h", pred_pc, 16'h0013); end
        checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin errors++; $display("FAIL cnt0_flags: got hit=%b taken=%b want 1 0", pred_hit, pred_taken); end
    endtask

    task automatic test_hysteresis();
        lookup_pc = 16'h0012;
        do_update(16'h0012, 16'h0040, 1'b0, 1'b1);
        #1;
        checks++; if (pred_pc !== 16'h0013) begin errors++; $display("FAIL cnt0_t_pc: got %h want %h", pred_pc, 16'h0013); end
        do_update(16'h0012, 16'h0040, 1'b0, 1'b1);
        #1;
        checks++; if (pred_pc !== 16'h0040) begin errors++; $display("FAIL cnt1_t_pc: got %h want %h", pred_pc, 16'h0040); end
        do_update(16'h0012, 16'h0050, 1'b0, 1'b1);
        #1;
        checks++; if (pred_pc !== 16'h0050) begin errors++; $display("FAIL taken_retarget_pc: got %h want %h", pred_pc, 16'h0050); end
        do_update(16'h0012, 16'h0077, 1'b0, 1'b0);
        #1;
        checks++; if (pred_pc !== 16'h0050) begin errors++; $display("FAIL cnt3_n_keeps_target: got %h want %h", pred_pc, 16'h0050); end
        lookup_pc = 16'h0021;
        do_update(16'h0021, 16'h0099, 1'b0, 1'b0);
        #1;
        checks++; if (pred_hit !== 1'b1 || pred_pc !== 16'h0022) begin errors++; $display("FAIL alloc_nt: got hit=%b pc=%h want 1 0022", pred_hit, pred_pc); end
        do_update(16'h0021, 16'h0099, 1'b0, 1'b1);
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_nt_then_t: got taken=%b want 0", pred_taken); end
    endtask

    task automatic test_jump_alias();
        do_update(16'h0005, 16'h0100, 1'b1, 1'b0);
        lookup_pc = 16'h0005;
        #1;
        checks++; if (pred_pc !== 16'h0100 || pred_taken !== 1'b1) begin errors++; $display("FAIL jump_alloc: got pc=%h taken=%b want 0100 1", pred_pc, pred_taken); end
        lookup_pc = 16'h000D;
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_pc !== 16'h000E) begin errors++; $display("FAIL alias_miss: got hit=%b pc=%h want 0 000e", pred_hit, pred_pc); end
        do_update(16'h000D, 16'h0200, 1'b0, 1'b1);
        #1;
        checks++; if (pred_pc !== 16'h0200) begin errors++; $display("FAIL alias_replace_pc: got %h want %h", pred_pc, 16'h0200); end
        lookup_pc = 16'h0005;
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_pc !== 16'h0006) begin errors++; $display("FAIL alias_evicted: got hit=%b pc=%h want 0 0006", pred_hit, pred_pc); end
        lookup_pc = 16'h0003;
        do_update(16'h0003, 16'h0300, 1'b1, 1'b0);
        do_update(16'h0003, 16'h0310, 1'b1, 1'b0);
        #1;
        checks++; if (pred_pc !== 16'h0310 || pred_taken !== 1'b1) begin errors++; $display("FAIL jump_retarget: got pc=%h taken=%b want 0310 1", pred_pc, pred_taken); end
    endtask

    task automatic test_same_cycle();
        lookup_pc      = 16'h0030;
        update_pc      = 16'h0030;
        update_target  = 16'h0400;
        update_is_jump = 1'b1;
        update_taken   = 1'b1;
        update_valid   = 1'b1;
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_pc !== 16'h0031) begin errors++; $display("FAIL no_bypass: got hit=%b pc=%h want 0 0031", pred_hit, pred_pc); end
        tick();
        update_valid = 1'b0;
        #1;
        checks++; if (pred_hit !== 1'b1 || pred_pc !== 16'h0400) begin errors++; $display("FAIL after_update: got hit=%b pc=%h want 1 0400", pred_hit, pred_pc); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        do_update(16'h0020, 16'h0600, 1'b1, 1'b1);
        flush = 1'b0;
        lookup_pc = 16'h0020;
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_pc !== 16'h0021) begin errors++; $display("FAIL flush_drops_update: got hit=%b pc=%h want 0 0021", pred_hit, pred_pc); end
        lookup_pc = 16'h0030;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL flush_clears: got hit=%b want 0", pred_hit); end
        lookup_pc = 16'hFFFF;
        #1;
        checks++; if (pred_pc !== 16'h0000 || pred_hit !== 1'b0) begin errors++; $display("FAIL wrap_pc: got pc=%h hit=%b want 0000 0", pred_pc, pred_hit); end
    endtask

    task automatic test_reset_mid_update();
        lookup_pc = 16'h0040;
        do_update(16'h0040, 16'h0500, 1'b1, 1'b1);
        #1;
        checks++; if (pred_hit !== 1'b1) begin errors++; $display("FAIL pre_reset_hit: got %b want 1", pred_hit); end
        update_pc      = 16'h0048;
        update_target  = 16'h0700;
        update_valid   = 1'b1;
        Reset_N        = 1'b0;
        tick();
        update_valid   = 1'b0;
        Reset_N        = 1'b1;
        #1;
        checks++; if (pred_hit !== 1'b0 || pred_pc !== 16'h0041) begin errors++; $display("FAIL reset_clears: got hit=%b pc=%h want 0 0041", pred_hit, pred_pc); end
        lookup_pc = 16'h0048;
        #1;
        checks++; if (pred_hit !== 1'b0) begin errors++; $display("FAIL reset_drops_update: got hit=%b want 0", pred_hit); end
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats();
        Reset_N = 1'b0;
        tick();
        Reset_N = 1'b1;
        checks++; if (stat_lookups !== 16'd0 || stat_mispredicts !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d %0d want 0 0", stat_lookups, stat_mispredicts); end
        lookup_en = 1'b1;
        tick(); tick(); tick();
        lookup_en = 1'b0;
        update_mispredict = 1'b1;
        do_update(16'h0001, 16'h0010, 1'b0, 1'b1);
        do_update(16'h0002, 16'h0020, 1'b0, 1'b1);
        flush = 1'b1;
        do_update(16'h0003, 16'h0030, 1'b0, 1'b1);
        flush = 1'b0;
        checks++; if (stat_lookups !== 16'd3) begin errors++; $display("FAIL stat_lookups: got %0d want 3", stat_lookups); end
        checks++; if (stat_mispredicts !== 16'd2) begin errors++; $display("FAIL stat_mispredicts: got %0d want 2", stat_mispredicts); end
        lookup_en    = 1'b1;
        update_valid = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        lookup_en    = 1'b0;
        update_valid = 1'b0;
        update_mispredict = 1'b0;
        checks++; if (stat_lookups !== 16'hFFFF || stat_mispredicts !== 16'hFFFF) begin errors++; $display("FAIL stat_saturate: got %h %h want ffff ffff", stat_lookups, stat_mispredicts); end
    endtask
`endif

    initial begin
        lookup_en         = 1'b0;
        lookup_pc         = 16'h0000;
        update_valid      = 1'b0;
        update_pc         = 16'h0000;
        update_target     = 16'h0000;
        update_is_jump    = 1'b0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
        flush             = 1'b0;
        test_reset();
        test_branch_basic();
        test_hysteresis();
        test_jump_alias();
        test_same_cycle();
        test_flush();
        test_reset_mid_update();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
